// File: rtl/axi4l_int_pkg.sv
// Shared constants and state encoding for the AXI4-Lite to internal register-bus bridge.
package axi4l_int_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int ARB_RR = 0;
    localparam int ARB_WR = 1;
    localparam int ARB_RD = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/axi4l_skid1.sv
// One-entry skid buffer: ready stays high unless the entry is held and not taken this cycle.
module axi4l_skid1 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         consume
);

    logic         live_q;
    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // live_q keeps ready low while reset is held and for nothing longer than one edge after release
    assign in_ready  = live_q && (!full_q || consume);
    assign out_valid = full_q;
    assign out_data  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (consume) begin
            full_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            live_q <= 1'b1;
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/axi4l_int_to.sv
// AXI4-Lite slave bridged onto a strobe/ack internal register bus, one transaction in flight,
// with address decode errors, ack timeout and selectable read/write arbitration.
module axi4l_int_to
    import axi4l_int_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_LIMIT     = 1024,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ARB_MODE       = 0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ADDR_WIDTH-1:0]   int_addr,
    output logic [DATA_WIDTH-1:0]   int_wr_data,
    output logic [DATA_WIDTH/8-1:0] int_wr_strb,
    output logic                    int_wr_en,
    output logic                    int_rd_en,
    input  logic                    int_wr_ack,
    input  logic                    int_wr_err,
    input  logic                    int_rd_ack,
    input  logic                    int_rd_err,
    input  logic [DATA_WIDTH-1:0]   int_rd_data,
    output logic                    timeout_pulse
);

    localparam int          SW      = DATA_WIDTH / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic                  aw_v, w_v, ar_v, wr_take, rd_take;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [SW-1:0]         w_strb;

    axi4l_skid1 #(.W(ADDR_WIDTH)) u_aw (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn),
        .in_valid(s_axi_awvalid), .in_ready(s_axi_awready), .in_data(s_axi_awaddr),
        .out_valid(aw_v), .out_data(aw_addr), .consume(wr_take)
    );
    axi4l_skid1 #(.W(DATA_WIDTH + SW)) u_w (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn),
        .in_valid(s_axi_wvalid), .in_ready(s_axi_wready), .in_data({s_axi_wdata, s_axi_wstrb}),
        .out_valid(w_v), .out_data({w_data, w_strb}), .consume(wr_take)
    );
    axi4l_skid1 #(.W(ADDR_WIDTH)) u_ar (
        .clk(s_axi_aclk), .rst_n(s_axi_aresetn),
        .in_valid(s_axi_arvalid), .in_ready(s_axi_arready), .in_data(s_axi_araddr),
        .out_valid(ar_v), .out_data(ar_addr), .consume(rd_take)
    );

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] int_addr_q, int_addr_d;
    logic [DATA_WIDTH-1:0] int_wr_data_q, int_wr_data_d;
    logic [SW-1:0]         int_wr_strb_q, int_wr_strb_d;
    logic                  int_wr_en_q, int_wr_en_d, int_rd_en_q, int_rd_en_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  timeout_pulse_q, timeout_pulse_d;
    logic                  wr_cand, rd_cand, pick_wr, to_hit, aw_dec, ar_dec;

    assign wr_cand = aw_v && w_v && !bvalid_q;
    assign rd_cand = ar_v && !rvalid_q;
    assign aw_dec  = 32'(aw_addr) >= ADDR_LIMIT;
    assign ar_dec  = 32'(ar_addr) >= ADDR_LIMIT;
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // rr_q == 0 means the write side holds priority for the next contested grant
    always_comb begin
        if (ARB_MODE == ARB_WR)      pick_wr = 1'b1;
        else if (ARB_MODE == ARB_RD) pick_wr = 1'b0;
        else                         pick_wr = !rr_q;
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rr_d            = rr_q;
        int_addr_d      = int_addr_q;
        int_wr_data_d   = int_wr_data_q;
        int_wr_strb_d   = int_wr_strb_q;
        int_wr_en_d     = 1'b0;
        int_rd_en_d     = 1'b0;
        bvalid_d        = bvalid_q;
        bresp_d         = bresp_q;
        rvalid_d        = rvalid_q;
        rresp_d         = rresp_q;
        rdata_d         = rdata_q;
        timeout_pulse_d = 1'b0;
        wr_take         = 1'b0;
        rd_take         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_cand && (!rd_cand || pick_wr)) begin
                    wr_take = 1'b1;
                    rr_d    = 1'b1;
                    if (aw_dec) begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_DECERR;
                        state_d  = ST_RESP;
                    end else begin
                        int_addr_d    = aw_addr;
                        int_wr_data_d = w_data;
                        int_wr_strb_d = w_strb;
                        int_wr_en_d   = 1'b1;
                        cnt_d         = '0;
                        state_d       = ST_WR_WAIT;
                    end
                end else if (rd_cand) begin
                    rd_take = 1'b1;
                    rr_d    = 1'b0;
                    if (ar_dec) begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_DECERR;
                        rdata_d  = '0;
                        state_d  = ST_RESP;
                    end else begin
                        int_addr_d  = ar_addr;
                        int_rd_en_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (int_wr_ack) begin
                    bvalid_d = 1'b1;
                    bresp_d  = int_wr_err ? RESP_SLVERR : RESP_OKAY;
                    state_d  = ST_RESP;
                end else if (to_hit) begin
                    bvalid_d        = 1'b1;
                    bresp_d         = RESP_SLVERR;
                    timeout_pulse_d = 1'b1;
                    state_d         = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RD_WAIT: begin
                if (int_rd_ack) begin
                    rvalid_d = 1'b1;
                    rresp_d  = int_rd_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d  = int_rd_data;
                    state_d  = ST_RESP;
                end else if (to_hit) begin
                    rvalid_d        = 1'b1;
                    rresp_d         = RESP_SLVERR;
                    rdata_d         = '0;
                    timeout_pulse_d = 1'b1;
                    state_d         = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (bvalid_q && s_axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
                if (rvalid_q && s_axi_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            rr_q            <= 1'b0;
            int_addr_q      <= '0;
            int_wr_data_q   <= '0;
            int_wr_strb_q   <= '0;
            int_wr_en_q     <= 1'b0;
            int_rd_en_q     <= 1'b0;
            bvalid_q        <= 1'b0;
            bresp_q         <= '0;
            rvalid_q        <= 1'b0;
            rresp_q         <= '0;
            rdata_q         <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rr_q            <= rr_d;
            int_addr_q      <= int_addr_d;
            int_wr_data_q   <= int_wr_data_d;
            int_wr_strb_q   <= int_wr_strb_d;
            int_wr_en_q     <= int_wr_en_d;
            int_rd_en_q     <= int_rd_en_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            rvalid_q        <= rvalid_d;
            rresp_q         <= rresp_d;
            rdata_q         <= rdata_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign int_addr      = int_addr_q;
    assign int_wr_data   = int_wr_data_q;
    assign int_wr_strb   = int_wr_strb_q;
    assign int_wr_en     = int_wr_en_q;
    assign int_rd_en     = int_rd_en_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_axi4l_int_to.sv
// Bench for axi4l_int_to: directed scenarios plus randomized single transactions against a cycle-level model.
module tb_axi4l_int_to;

    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int LIM = 1024;
    localparam int TO  = 8;

    logic clk;
    logic rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic awvalid, wvalid, arvalid, bready, rready;
    logic [DW-1:0] wdata;
    logic [3:0] wstrb;
    logic man_wr_ack, man_wr_err, man_rd_ack, man_rd_err, auto_ack;
    logic [DW-1:0] man_rd_data;

    logic awready, wready, arready, bvalid, rvalid, int_wr_en, int_rd_en, timeout_pulse;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata, int_wr_data;
    logic [AW-1:0] int_addr;
    logic [3:0] int_wr_strb;
    logic wr_ack, rd_ack;

    logic p_awready, p_wready, p_arready, p_bvalid, p_rvalid, p_wr_en, p_rd_en, p_to;
    logic [1:0] p_bresp, p_rresp;
    logic [DW-1:0] p_rdata, p_wr_data;
    logic [AW-1:0] p_addr;
    logic [3:0] p_wr_strb;

    assign wr_ack = man_wr_ack | (auto_ack & int_wr_en);
    assign rd_ack = man_rd_ack | (auto_ack & int_rd_en);

    axi4l_int_to #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LIMIT(LIM), .TIMEOUT_CYCLES(TO), .ARB_MODE(0)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .int_addr(int_addr), .int_wr_data(int_wr_data), .int_wr_strb(int_wr_strb),
        .int_wr_en(int_wr_en), .int_rd_en(int_rd_en),
        .int_wr_ack(wr_ack), .int_wr_err(man_wr_err),
        .int_rd_ack(rd_ack), .int_rd_err(man_rd_err), .int_rd_data(man_rd_data),
        .timeout_pulse(timeout_pulse)
    );

    // Write-priority instance sharing the AXI stimulus; its register bus always acks at once.
    axi4l_int_to #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LIMIT(LIM), .TIMEOUT_CYCLES(TO), .ARB_MODE(1)) dut_wp (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(p_awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(p_wready),
        .s_axi_bresp(p_bresp), .s_axi_bvalid(p_bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(p_arready),
        .s_axi_rdata(p_rdata), .s_axi_rresp(p_rresp), .s_axi_rvalid(p_rvalid), .s_axi_rready(rready),
        .int_addr(p_addr), .int_wr_data(p_wr_data), .int_wr_strb(p_wr_strb),
        .int_wr_en(p_wr_en), .int_rd_en(p_rd_en),
        .int_wr_ack(p_wr_en), .int_wr_err(1'b0),
        .int_rd_ack(p_rd_en), .int_rd_err(1'b0), .int_rd_data(32'h0),
        .timeout_pulse(p_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    bit q_a[$];
    bit q_b[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        man_wr_ack = 0; man_wr_err = 0; man_rd_ack = 0; man_rd_err = 0;
        man_rd_data = '0; auto_ack = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // One AXI transaction; the expected outcome follows from address range, ack delay and timeout rules.
    task automatic xact(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] strb, input int dly, input bit err, input int hold,
                        input string tag);
        bit dec, st_seen, vseen, done, changed, prev_v, cur_v, aw_hs, w_hs, ar_hs;
        logic [1:0] exp_resp, resp_c;
        logic [DW-1:0] exp_rdata, rdata_c, idata_c;
        logic [AW-1:0] iaddr_c;
        logic [3:0] istrb_c;
        int exp_vlat, exp_pulse, st, vlat, done_lat, nstrobe, nother, npulse, nrise, bound;
        dec = int'(addr) >= LIM;
        if (dec) begin
            exp_resp = 2'b11; exp_rdata = '0; exp_vlat = 2; exp_pulse = 0;
        end else if (dly < TO) begin
            exp_resp = err ? 2'b10 : 2'b00; exp_rdata = data; exp_vlat = 3 + dly; exp_pulse = 0;
        end else begin
            exp_resp = 2'b10; exp_rdata = '0; exp_vlat = 2 + TO; exp_pulse = 1;
        end
        st_seen = 0; vseen = 0; done = 0; changed = 0; prev_v = 0;
        st = 0; vlat = 0; done_lat = 0; nstrobe = 0; nother = 0; npulse = 0; nrise = 0;
        resp_c = 'x; rdata_c = 'x; iaddr_c = 'x; idata_c = 'x; istrb_c = 'x;
        if (is_wr) begin
            awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
        end else begin
            araddr = addr; arvalid = 1;
        end
        bound = 0;
        while ((awvalid || wvalid || arvalid) && bound < 20) begin
            aw_hs = awvalid && awready; w_hs = wvalid && wready; ar_hs = arvalid && arready;
            @(negedge clk);
            bound++;
            if (aw_hs) awvalid = 0;
            if (w_hs) wvalid = 0;
            if (ar_hs) arvalid = 0;
        end
        chk({tag, "_handshake"}, bound < 20, 1);
        awvalid = 0; wvalid = 0; arvalid = 0;
        for (int lat = 1; lat < 80; lat++) begin
            cur_v = is_wr ? bvalid : rvalid;
            if (is_wr ? int_wr_en : int_rd_en) begin
                nstrobe++;
                if (!st_seen) begin
                    st_seen = 1; st = lat; iaddr_c = int_addr; idata_c = int_wr_data; istrb_c = int_wr_strb;
                end
            end
            if (is_wr ? int_rd_en : int_wr_en) nother++;
            if (timeout_pulse) npulse++;
            if (cur_v && !prev_v) nrise++;
            if (cur_v && !vseen) begin
                vseen = 1; vlat = lat; resp_c = is_wr ? bresp : rresp; rdata_c = rdata;
            end else if (cur_v && !done) begin
                if ((is_wr ? bresp : rresp) !== resp_c || (!is_wr && rdata !== rdata_c)) changed = 1;
            end
            prev_v = cur_v;
            man_wr_ack = is_wr && st_seen && (lat == st + dly);
            man_rd_ack = !is_wr && st_seen && (lat == st + dly);
            man_wr_err = err; man_rd_err = err; man_rd_data = data;
            if (vseen && !done && lat >= vlat + hold) begin
                bready = is_wr; rready = !is_wr; done = 1; done_lat = lat;
            end else begin
                bready = 0; rready = 0;
            end
            if (done && lat > done_lat + 3 && (!st_seen || lat > st + dly + 3)) break;
            @(negedge clk);
        end
        man_wr_ack = 0; man_rd_ack = 0; bready = 0; rready = 0;
        chk({tag, "_strobes"}, nstrobe, dec ? 0 : 1);
        chk({tag, "_wrong_strobe"}, nother, 0);
        if (!dec) begin
            chk({tag, "_strobe_lat"}, st, 2);
            chk({tag, "_int_addr"}, iaddr_c, addr);
            if (is_wr) begin
                chk({tag, "_int_wdata"}, idata_c, data);
                chk({tag, "_int_wstrb"}, istrb_c, strb);
            end
        end
        chk({tag, "_valid_lat"}, vlat, exp_vlat);
        chk({tag, "_resp"}, resp_c, exp_resp);
        if (!is_wr) chk({tag, "_rdata"}, rdata_c, exp_rdata);
        chk({tag, "_timeout_pulses"}, npulse, exp_pulse);
        chk({tag, "_valid_rises"}, nrise, 1);
        chk({tag, "_resp_stable"}, changed, 0);
    endtask

    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    int            r_wait;

    initial begin
        rst_n = 0;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_strobes", {int_wr_en, int_rd_en, timeout_pulse}, 0);
        chk("rst_int_addr", int_addr, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rel_readies", {awready, wready, arready}, 3'b111);

        xact(1, 11'h010, 32'hDEADBEEF, 4'hF, 0, 0, 1, "t1_write");
        xact(0, 11'h3FC, 32'h12345678, 4'h0, 5, 1, 0, "t2_read_err");
        xact(0, 11'h400, 32'hA5A5A5A5, 4'h0, 0, 0, 0, "t3_decerr");
        xact(1, 11'h080, 32'h00C0FFEE, 4'h3, TO + 3, 0, 1, "t4_timeout");
        xact(1, 11'h084, 32'h11112222, 4'hC, TO - 1, 0, 0, "t4_ack_at_limit");
        xact(1, 11'h7FF, 32'h33334444, 4'hF, 0, 0, 2, "decerr_write");

        for (int i = 0; i < 16; i++) begin
            r_addr = AW'($urandom_range(0, 1279));
            r_data = $urandom;
            xact($urandom_range(0, 1) == 1, r_addr, r_data, 4'($urandom_range(0, 15)),
                 $urandom_range(0, TO + 2), $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                 $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        do_reset();
        auto_ack = 1; bready = 1; rready = 1;
        awaddr = 11'h020; wdata = 32'h5555AAAA; wstrb = 4'hF; araddr = 11'h024;
        awvalid = 1; wvalid = 1; arvalid = 1;
        repeat (40) begin
            @(negedge clk);
            if (int_wr_en) q_a.push_back(1'b1); else if (int_rd_en) q_a.push_back(1'b0);
            if (p_wr_en) q_b.push_back(1'b1); else if (p_rd_en) q_b.push_back(1'b0);
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("arb_rr_count", q_a.size() >= 4, 1);
        chk("arb_wp_count", q_b.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("arb_rr_grant%0d", i), (i < q_a.size()) ? 2'(q_a[i]) : 2'd2, 2'((i % 2) == 0));
            chk($sformatf("arb_wp_grant%0d", i), (i < q_b.size()) ? 2'(q_b[i]) : 2'd2, 2'd1);
        end

        do_reset();
        auto_ack = 1;
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        repeat (3) @(negedge clk);
        chk("t6_wready_held", wready, 0);
        chk("t6_awready_free", awready, 1);
        chk("t6_no_strobe_yet", int_wr_en, 0);
        awaddr = 11'h040; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        r_wait = 0;
        while (!bvalid && r_wait < 10) begin
            @(negedge clk);
            r_wait++;
        end
        chk("t6_bvalid_seen", bvalid, 1);
        repeat (10) @(negedge clk);
        chk("t6_bvalid_held", bvalid, 1);
        chk("t6_bresp", bresp, 2'b00);
        rst_n = 0;
        #1;
        chk("t6_rst_bvalid", bvalid, 0);
        chk("t6_rst_readies", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("t6_rel_readies", {awready, wready, arready}, 3'b111);
        chk("t6_rel_bvalid", bvalid, 0);
        repeat (3) @(negedge clk);
        chk("t6_no_stale_strobe", {int_wr_en, int_rd_en, bvalid, rvalid}, 4'b0000);

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
